// File: rtl/dbg_read_arbiter.sv
// Round-robin sequencer for the byte-wide debug readout mux.
// Optional DBG_SWI_WRITE_EN: SWI override register written by 0100xxxv commands.
module dbg_read_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_req,
  input  logic [7:0] h_cmd,
  output logic       h_gnt,
  output logic       h_rvalid,
  output logic [7:0] h_rdata,
  input  logic       s_req,
  input  logic [7:0] s_cmd,
  output logic       s_gnt,
  output logic       s_rvalid,
  output logic [7:0] s_rdata,
  output logic [7:0] mux_sel,
  input  logic [7:0] mux_data,
  output logic [7:0] SWI_JTAG,
  output logic       busy
);

  if ((RD_LAT < 1) || (RD_LAT > 7)) begin : g_bad_lat
    $error("dbg_read_arbiter: RD_LAT must be 1..7");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  // last/owner: 1 = scanner, 0 = host
  logic       last, last_n;
  logic       owner, owner_n;
  logic [7:0] sel_n, hrd_n, srd_n;
  logic       hg_n, sg_n, hv_n, sv_n;
  logic       pick_s;
  logic [7:0] win_cmd;

  assign pick_s  = s_req & (~h_req | ~last);
  assign win_cmd = pick_s ? s_cmd : h_cmd;
  assign busy    = (state != IDLE);

`ifdef DBG_SWI_WRITE_EN
  logic [7:0] swi, swi_n;
  assign SWI_JTAG = swi;
`else
  assign SWI_JTAG = 8'h00;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    owner_n = owner;
    sel_n   = mux_sel;
    hrd_n   = h_rdata;
    srd_n   = s_rdata;
    hg_n    = 1'b0;
    sg_n    = 1'b0;
    hv_n    = 1'b0;
    sv_n    = 1'b0;
`ifdef DBG_SWI_WRITE_EN
    swi_n   = swi;
`endif
    unique case (state)
      IDLE: begin
        if (h_req | s_req) begin
          state_n = WAIT;
          sel_n   = win_cmd;
          cnt_n   = 3'(RD_LAT - 1);
          last_n  = pick_s;
          owner_n = pick_s;
          hg_n    = ~pick_s;
          sg_n    = pick_s;
`ifdef DBG_SWI_WRITE_EN
          if (win_cmd[7:4] == 4'b0100)
            swi_n[win_cmd[3:1]] = win_cmd[0];
`endif
        end
      end
      WAIT: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else begin
          state_n = IDLE;
          if (owner) begin
            srd_n = mux_data;
            sv_n  = 1'b1;
          end else begin
            hrd_n = mux_data;
            hv_n  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      last     <= 1'b1;
      owner    <= 1'b0;
      mux_sel  <= 8'h00;
      h_rdata  <= 8'h00;
      s_rdata  <= 8'h00;
      h_gnt    <= 1'b0;
      s_gnt    <= 1'b0;
      h_rvalid <= 1'b0;
      s_rvalid <= 1'b0;
`ifdef DBG_SWI_WRITE_EN
      swi      <= 8'h00;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      owner    <= owner_n;
      mux_sel  <= sel_n;
      h_rdata  <= hrd_n;
      s_rdata  <= srd_n;
      h_gnt    <= hg_n;
      s_gnt    <= sg_n;
      h_rvalid <= hv_n;
      s_rvalid <= sv_n;
`ifdef DBG_SWI_WRITE_EN
      swi      <= swi_n;
`endif
    end
  end

endmodule

// File: tb/tb_dbg_read_arbiter.sv
// Scoreboard bench for dbg_read_arbiter: four instances, RD_LAT = 2, 4, 1, 7.
// Mux model returns sel^A5 only once sel has been stable RD_LAT cycles.
module tb_dbg_read_arbiter;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       rst      [4];
  logic       h_req    [4];
  logic [7:0] h_cmd    [4];
  logic       h_gnt    [4];
  logic       h_rvalid [4];
  logic [7:0] h_rdata  [4];
  logic       s_req    [4];
  logic [7:0] s_cmd    [4];
  logic       s_gnt    [4];
  logic       s_rvalid [4];
  logic [7:0] s_rdata  [4];
  logic [7:0] mux_sel  [4];
  logic [7:0] mux_data [4];
  logic [7:0] swi      [4];
  logic       busy     [4];

  logic [7:0] swi_m [4];
  int         gcyc  [4];

  typedef struct {
    int         inst;
    bit         host;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int k);
    case (k)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 7;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 7;
    logic [7:0] prev;
    logic [3:0] age;
    logic [3:0] eff;

    dbg_read_arbiter #(.RD_LAT(L)) dut (
      .clk      (clk),
      .reset    (rst[g]),
      .h_req    (h_req[g]),
      .h_cmd    (h_cmd[g]),
      .h_gnt    (h_gnt[g]),
      .h_rvalid (h_rvalid[g]),
      .h_rdata  (h_rdata[g]),
      .s_req    (s_req[g]),
      .s_cmd    (s_cmd[g]),
      .s_gnt    (s_gnt[g]),
      .s_rvalid (s_rvalid[g]),
      .s_rdata  (s_rdata[g]),
      .mux_sel  (mux_sel[g]),
      .mux_data (mux_data[g]),
      .SWI_JTAG (swi[g]),
      .busy     (busy[g])
    );

    always @(posedge clk) begin
      prev <= mux_sel[g];
      if (mux_sel[g] != prev) age <= 4'd1;
      else if (age != 4'd15)  age <= age + 4'd1;
    end
    assign eff = (mux_sel[g] != prev) ? 4'd0 : age;
    assign mux_data[g] = (eff >= 4'(L - 1)) ? (mux_sel[g] ^ 8'hA5) : 8'hEE;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (h_gnt[k] === 1'b1 && s_gnt[k] === 1'b1) chk("dual_gnt", 1, 0);
      if (h_gnt[k] === 1'b1 || s_gnt[k] === 1'b1) gcyc[k] = cyc;
      if (h_rvalid[k] === 1'b1 || s_rvalid[k] === 1'b1) begin
        if (h_rvalid[k] === 1'b1 && s_rvalid[k] === 1'b1) chk("dual_rv", 1, 0);
        if (q.size() == 0) begin
          chk("spur_rv", k, -1);
        end else begin
          e = q.pop_front();
          chk("rv_inst", k, e.inst);
          chk("rv_who", int'(h_rvalid[k]), int'(e.host));
          chk("rv_data", e.host ? h_rdata[k] : s_rdata[k], e.data);
          chk("rv_cyc", cyc - gcyc[k], lat_of(k));
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_gnt(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (h_gnt[k] !== 1'b1 && s_gnt[k] !== 1'b1 && n < 30);
    chk("gnt_seen", int'(h_gnt[k] === 1'b1 || s_gnt[k] === 1'b1), 1);
  endtask

  task automatic host_rd(input int k, input logic [7:0] cmd);
    int c0;
    @(negedge clk);
    h_cmd[k] = cmd;
    h_req[k] = 1'b1;
    c0 = cyc;
    q.push_back('{k, 1'b1, cmd ^ 8'hA5});
`ifdef DBG_SWI_WRITE_EN
    if (cmd[7:4] == 4'b0100) swi_m[k][cmd[3:1]] = cmd[0];
`endif
    wait_gnt(k);
    chk("h_gnt", int'(h_gnt[k]), 1);
    chk("gnt_cyc", cyc - c0, 1);
    chk("sel", mux_sel[k], cmd);
    chk("busy1", int'(busy[k]), 1);
    chk("swi", swi[k], swi_m[k]);
    h_req[k] = 1'b0;
    drain();
    @(negedge clk);
    chk("rdata_hold", h_rdata[k], cmd ^ 8'hA5);
    chk("busy0", int'(busy[k]), 0);
  endtask

  task automatic rst_pulse(input int k);
    @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    swi_m[k] = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_g;
    bit who;
    for (int k = 0; k < 4; k++) begin
      rst[k]   = 1'b1;
      h_req[k] = 1'($urandom_range(0, 1));
      s_req[k] = 1'($urandom_range(0, 1));
      h_cmd[k] = 8'($urandom);
      s_cmd[k] = 8'($urandom);
      swi_m[k] = 8'h00;
      gcyc[k]  = 0;
    end

    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        chk("rst_gnt", int'(h_gnt[k] | s_gnt[k]), 0);
    end
    for (int k = 0; k < 4; k++) begin
      h_req[k] = 1'b0;
      s_req[k] = 1'b0;
      chk("rst_sel", mux_sel[k], 0);
      chk("rst_hrd", h_rdata[k], 0);
      chk("rst_srd", s_rdata[k], 0);
      chk("rst_swi", swi[k], 0);
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_rv", int'(h_rvalid[k] | s_rvalid[k]), 0);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;

    host_rd(0, 8'h21);
    chk("s_rdata_keep", s_rdata[0], 0);

    host_rd(0, 8'h47);
    host_rd(0, 8'h46);

    rst_pulse(0);
    @(negedge clk);
    h_cmd[0] = 8'h03;
    s_cmd[0] = 8'h30;
    h_req[0] = 1'b1;
    s_req[0] = 1'b1;
    prev_g = 0;
    for (int i = 0; i < 4; i++) begin
      who = (i % 2) == 0;
      q.push_back('{0, who, who ? (8'h03 ^ 8'hA5) : (8'h30 ^ 8'hA5)});
      wait_gnt(0);
      chk("ct_who", int'(h_gnt[0]), int'(who));
      if (i > 0) chk("ct_gap", cyc - prev_g, lat_of(0) + 1);
      prev_g = cyc;
      if (i == 3) begin
        h_req[0] = 1'b0;
        s_req[0] = 1'b0;
      end
    end
    drain();

    @(negedge clk);
    h_cmd[1] = 8'h5C;
    h_req[1] = 1'b1;
    wait_gnt(1);
    h_req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    swi_m[1] = 8'h00;
    chk("mr_sel", mux_sel[1], 0);
    chk("mr_busy", int'(busy[1]), 0);
    repeat (8) @(negedge clk);
    host_rd(1, 8'h5C);

    host_rd(2, 8'h0A);
    host_rd(3, 8'h0A);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
